// File: rtl/rca_config_unit.sv
// rtl/rca_config_unit.sv - RCA register-address config unit with per-RCA in-flight drain
module rca_config_unit #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int MAX_IDS         = 8,
  localparam int IDW = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1,
  localparam int RSW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int PSW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [RSW-1:0]                                cfg_rca_sel,
  input  logic [PSW-1:0]                                cfg_port_sel,
  input  logic                                          cfg_src_dest,
  input  logic [4:0]                                    cfg_reg_addr,
  input  logic [IDW-1:0]                                cfg_id,
  output logic                                          wb_done,
  output logic [IDW-1:0]                                wb_id,
  input  logic                                          wb_ack,
  input  logic                                          use_issue,
  input  logic [RSW-1:0]                                use_rca_sel,
  output logic                                          use_ready,
  input  logic [NUM_RCAS-1:0]                           use_complete,
  output logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][4:0]  rca_src_reg_addrs,
  output logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][4:0] rca_dest_reg_addrs
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                                    state_q, state_d;
  logic [RSW-1:0]                                tgt_q;
  logic [PSW-1:0]                                port_q;
  logic                                          sd_q;
  logic [4:0]                                    reg_q;
  logic [IDW-1:0]                                id_q;
  logic [NUM_RCAS-1:0][2:0]                      cnt_q, cnt_d;
  logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][4:0]  src_q, src_d;
  logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][4:0] dst_q, dst_d;
  logic [2:0]                                    use_cnt, tgt_cnt;
  logic                                          use_fire, tbl_wr, cfg_fire;

  // Look up the in-flight count for the use target and the config target; out-of-range selects read as idle
  always_comb begin
    use_cnt = '0;
    tgt_cnt = '0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (use_rca_sel == RSW'(i)) use_cnt = cnt_q[i];
      if (tgt_q == RSW'(i))       tgt_cnt = cnt_q[i];
    end
  end

  // A use may not enter an RCA that is saturated or whose addresses are being rewritten
  assign use_ready = (use_cnt != 3'd7) && !((state_q != ST_IDLE) && (use_rca_sel == tgt_q));
  assign use_fire  = use_issue && use_ready;
  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign tbl_wr    = (state_q == ST_DRAIN) && (tgt_cnt == 3'd0);
  assign wb_done   = (state_q == ST_DONE);
  assign wb_id     = id_q;
  assign rca_src_reg_addrs  = src_q;
  assign rca_dest_reg_addrs = dst_q;

  // In-flight counters: issue and completion in the same cycle cancel; completions at zero are dropped
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if ((use_fire && (use_rca_sel == RSW'(i))) && !(use_complete[i] && (cnt_q[i] != 3'd0)))
        cnt_d[i] = cnt_q[i] + 3'd1;
      else if (!(use_fire && (use_rca_sel == RSW'(i))) && (use_complete[i] && (cnt_q[i] != 3'd0)))
        cnt_d[i] = cnt_q[i] - 3'd1;
    end
  end

  // Config sequencing: accept, wait for the target RCA to go idle, then report completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (tgt_cnt == 3'd0) state_d = ST_DONE;
      ST_DONE:  if (wb_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Table update; writes to a nonexistent RCA or slot fall through without touching any entry
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    if (tbl_wr) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        if (tgt_q == RSW'(r)) begin
          if (!sd_q) begin
            for (int p = 0; p < NUM_READ_PORTS; p++)
              if (port_q == PSW'(p)) src_d[r][p] = reg_q;
          end else begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++)
              if (port_q == PSW'(p)) dst_d[r][p] = reg_q;
          end
        end
      end
    end
  end

  // State registers with synchronous reset; a reset mid-config drops it without writing or completing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      tgt_q   <= '0;
      port_q  <= '0;
      sd_q    <= 1'b0;
      reg_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      if (cfg_fire) begin
        tgt_q  <= cfg_rca_sel;
        port_q <= cfg_port_sel;
        sd_q   <= cfg_src_dest;
        reg_q  <= cfg_reg_addr;
        id_q   <= cfg_id;
      end
    end
  end

endmodule
